gshare_branch_predictor: RTL and testbench

- Parametrised successor to the per-index 2-bit counter predictor.
- Adds global history (gshare index = PC bits XOR GHR), configurable counter width, speculative history update with mispredict repair, a self-initialising table sweep after reset, and a saturating mispredict counter.
- Sits in the fetch stage: prediction is combinational from the fetch PC. Updates come from the branch-resolve stage.

---
 rtl/gshare_branch_predictor.sv | 141 ++++++++++++++
 tb/tb_gshare_branch_predictor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Fetch-stage direction predictor. The table index is the fetch PC word
//   address XORed with a global history register (GHR). Each table entry is a
//   CTR_W-bit saturating counter. After reset, a sweep writes every entry to
//   weakly-not-taken before ready rises.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   ready          table sweep finished, predictor usable
//   pr_valid       branch fetched this cycle; commits the speculative GHR shift
//   pr_pc          fetch PC (bit 0 ignored)
//   pr_taken       predicted direction (combinational)
//   pr_index       table index used (carried to up_index)
//   pr_ghr         GHR checkpoint used (carried to up_ghr)
//   up_valid       resolved branch update
//   up_index       index returned from pr_index
//   up_ghr         checkpoint returned from pr_ghr
//   up_taken       actual direction
//   up_mispredict  resolved direction differed from prediction
//   miss_count     saturating mispredict counter
module gshare_branch_predictor #(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              pr_valid,
  input  logic [15:0]       pr_pc,
  output logic              pr_taken,
  output logic [IDX_W-1:0]  pr_index,
  output logic [HIST_W-1:0] pr_ghr,
  input  logic              up_valid,
  input  logic [IDX_W-1:0]  up_index,
  input  logic [HIST_W-1:0] up_ghr,
  input  logic              up_taken,
  input  logic              up_mispredict,
  output logic [15:0]       miss_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  ptr;
  logic [HIST_W-1:0] ghr, ghr_rep, ghr_spec;
  logic [IDX_W-1:0]  ghr_ext;
  logic [CTR_W-1:0]  ctr_tbl [ENTRIES];
  logic [CTR_W-1:0]  ctr_cur, ctr_nxt;
  logic              repair;

  // PC bits above the index and bit 0, and the checkpoint MSB, do not feed
  // any logic; fold them here so they are visibly accounted for.
  logic unused_bits;
  assign unused_bits = ^{pr_pc, up_ghr};

  assign ready = (state == READY);

  // GHR sits in the low bits of the index; upper bits are zero when
  // HIST_W < IDX_W.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr;
  end

  assign pr_index = pr_pc[IDX_W:1] ^ ghr_ext;
  assign pr_ghr   = ghr;
  // Read sees the pre-update value; no same-cycle bypass.
  assign pr_taken = ready & ctr_tbl[pr_index][CTR_W-1];

  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_rep  = up_taken;
      assign ghr_spec = pr_taken;
    end else begin : g_histn
      assign ghr_rep  = {up_ghr[HIST_W-2:0], up_taken};
      assign ghr_spec = {ghr[HIST_W-2:0], pr_taken};
    end
  endgenerate

  assign repair = up_valid & up_mispredict;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (ptr == IDX_W'(ENTRIES - 1)) state_n = READY;
      READY:   state_n = READY;
      default: state_n = INIT;
    endcase
  end

  // Sweep pointer
  always_ff @(posedge clk) begin
    if (rst)                ptr <= '0;
    else if (state == INIT) ptr <= ptr + 1'b1;
  end

  // Counter update
  always_comb begin
    ctr_cur = ctr_tbl[up_index];
    ctr_nxt = ctr_cur;
    if (up_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0)      ctr_nxt = ctr_cur - 1'b1;
    end
  end

  // Table has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)  ctr_tbl[ptr]      <= CTR_INIT;
      else if (up_valid)  ctr_tbl[up_index] <= ctr_nxt;
    end
  end

  // GHR: mispredict repair wins over a same-cycle speculative shift.
  always_ff @(posedge clk) begin
    if (rst)           ghr <= '0;
    else if (ready) begin
      if (repair)        ghr <= ghr_rep;
      else if (pr_valid) ghr <= ghr_spec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                   miss_count <= '0;
    else if (ready && repair && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        pr_valid;
  logic [15:0] pr_pc;
  logic        pr_taken;
  logic [5:0]  pr_index;
  logic [5:0]  pr_ghr;
  logic        up_valid;
  logic [5:0]  up_index;
  logic [5:0]  up_ghr;
  logic        up_taken;
  logic        up_mispredict;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor #(.IDX_W(6), .HIST_W(6), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .pr_valid(pr_valid), .pr_pc(pr_pc), .pr_taken(pr_taken),
    .pr_index(pr_index), .pr_ghr(pr_ghr),
    .up_valid(up_valid), .up_index(up_index), .up_ghr(up_ghr),
    .up_taken(up_taken), .up_mispredict(up_mispredict),
    .miss_count(miss_count)
  );

  typedef struct {
    logic        up_v;
    logic [5:0]  up_idx;
    logic        up_t;
    logic [15:0] pc;
    logic        exp_t;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pr_valid = 0; up_valid = 0; up_mispredict = 0; up_taken = 0;
    up_index = 0; up_ghr = 0;
  endtask

  task automatic upd(input logic [5:0] idx, input logic t, input logic mis, input logic [5:0] g);
    up_valid = 1; up_index = idx; up_taken = t; up_mispredict = mis; up_ghr = g;
    step();
    idle();
  endtask

  // Count cycles with ready high over the 64-cycle sweep, optionally
  // poking updates/fetches that must be ignored.
  task automatic init_window(input string name, input logic poke);
    int hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (ready) hi++;
      if (poke) begin
        up_valid = 1; up_mispredict = 1; up_taken = 1; up_index = 6'(i);
        pr_valid = 1;
      end
      step();
    end
    idle();
    chk({name, "_ready_low_64"}, hi, 0);
    chk({name, "_ready_at_64"}, ready, 1);
  endtask

  initial begin
    // saturation sequence at index 5, GHR = 0 (pr_pc 0x000A)
    vecs[0]  = '{1'b1, 6'd5, 1'b1, 16'h000A, 1'b0, 6'd5}; // 01->10
    vecs[1]  = '{1'b1, 6'd5, 1'b1, 16'h000A, 1'b1, 6'd5}; // 10->11
    vecs[2]  = '{1'b1, 6'd5, 1'b1, 16'h000A, 1'b1, 6'd5}; // 11 held
    vecs[3]  = '{1'b0, 6'd5, 1'b0, 16'h000A, 1'b1, 6'd5};
    vecs[4]  = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b1, 6'd5}; // 11->10
    vecs[5]  = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b1, 6'd5}; // 10->01
    vecs[6]  = '{1'b0, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5};
    vecs[7]  = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5}; // 01->00
    vecs[8]  = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5}; // 00 held
    vecs[9]  = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5};
    vecs[10] = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5};
    vecs[11] = '{1'b1, 6'd5, 1'b0, 16'h000A, 1'b0, 6'd5};
    vecs[12] = '{1'b1, 6'd5, 1'b1, 16'h000A, 1'b0, 6'd5}; // 00->01
    vecs[13] = '{1'b1, 6'd5, 1'b1, 16'h000A, 1'b0, 6'd5}; // 01->10
    vecs[14] = '{1'b0, 6'd5, 1'b0, 16'h000A, 1'b1, 6'd5};
    vecs[15] = '{1'b0, 6'd0, 1'b0, 16'h000C, 1'b0, 6'd6}; // untouched index 6

    idle();
    pr_pc = 16'h000C;
    rst = 1;
    step();
    step();
    chk("rst_ready", ready, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_ghr", pr_ghr, 0);
    chk("rst_taken", pr_taken, 0);
    chk("rst_index", pr_index, 6);
    rst = 0;

    init_window("init", 1'b1);
    chk("init_miss", miss_count, 0);
    chk("init_ghr", pr_ghr, 0);

    begin
      int taken_cnt = 0;
      for (int i = 0; i < 64; i++) begin
        pr_pc = 16'(i << 1);
        #1;
        if (pr_taken !== 1'b0 || pr_index !== 6'(i)) taken_cnt++;
      end
      chk("init_all_not_taken", taken_cnt, 0);
    end

    for (int i = 0; i < 16; i++) begin
      pr_pc = vecs[i].pc;
      up_valid = vecs[i].up_v; up_index = vecs[i].up_idx; up_taken = vecs[i].up_t;
      #1;
      chk($sformatf("vec%0d_taken", i), pr_taken, vecs[i].exp_t);
      chk($sformatf("vec%0d_index", i), pr_index, vecs[i].exp_idx);
      step();
      idle();
    end
    // index 5 now holds 10

    // GHR index
    pr_pc = 16'h0000; pr_valid = 1;
    step(); step(); step();
    pr_valid = 0;
    chk("ghr_after_nt", pr_ghr, 0);
    upd(6'd6, 1'b1, 1'b0, 6'd0);
    upd(6'd6, 1'b1, 1'b0, 6'd0);          // index 6 = 11
    pr_pc = 16'h000C; #1;
    chk("ghr0_index", pr_index, 6);
    chk("ghr0_taken", pr_taken, 1);
    pr_valid = 1; step();                  // GHR = 000001
    pr_pc = 16'h000E; #1;
    chk("ghr1_val", pr_ghr, 6'h01);
    chk("ghr1_index", pr_index, 6);
    chk("ghr1_taken", pr_taken, 1);
    step(); pr_valid = 0;                  // GHR = 000011
    pr_pc = 16'h000C; #1;
    chk("ghr3_val", pr_ghr, 6'h03);
    chk("ghr3_index", pr_index, 5);
    chk("ghr3_taken", pr_taken, 1);

    // repair priority
    upd(6'd63, 1'b0, 1'b1, 6'b010101);   // GHR = 101010, miss = 1
    chk("rep_setup_ghr", pr_ghr, 6'b101010);
    chk("rep_setup_miss", miss_count, 1);
    pr_valid = 1;
    upd(6'd63, 1'b0, 1'b1, 6'b000111);
    chk("rep_prio_ghr", pr_ghr, 6'b001110);
    chk("rep_prio_miss", miss_count, 2);

    // reset mid-operation
    upd(6'd63, 1'b0, 1'b1, 6'd0);        // GHR = 0, miss = 3
    upd(6'd2, 1'b1, 1'b0, 6'd0);
    upd(6'd2, 1'b1, 1'b0, 6'd0);         // index 2 = 11
    pr_pc = 16'h0004; #1;
    chk("pre_rst_miss", miss_count, 3);
    chk("pre_rst_idx2", pr_taken, 1);
    rst = 1; step(); rst = 0;
    chk("rst_ready_miss", miss_count, 0);
    chk("rst_ready_ghr", pr_ghr, 0);
    chk("rst_ready_low", ready, 0);
    for (int i = 0; i < 10; i++) step();
    rst = 1; step(); rst = 0;              // reset again mid-sweep
    init_window("reinit", 1'b0);
    pr_pc = 16'h0004; #1;
    chk("reinit_idx2_nt", pr_taken, 0);
    upd(6'd2, 1'b1, 1'b0, 6'd0);         // 01->10 proves it was 01
    #1;
    chk("reinit_idx2_01", pr_taken, 1);

    // miss_count saturation
    up_valid = 1; up_mispredict = 1; up_taken = 0; up_index = 0; up_ghr = 0;
    for (int i = 0; i < 100; i++) step();
    chk("miss_100", miss_count, 100);
    for (int i = 100; i < 65535; i++) step();
    chk("miss_ffff", miss_count, 16'hFFFF);
    step(); step();
    idle();
    chk("miss_sat", miss_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
